clk_switch_ctrl: RTL and testbench

- Sequencer and arbiter for a glitch-free clock-source mux bank.
- Runs on an always-on control clock.
- Accepts clock-switch requests from NUM_REQ requesters (e.g. power manager, CSR block) and grants them round-robin.
- For each granted switch: gates off the current source, waits for the mux's off-acknowledge, enables the new source, waits for its on-acknowledge, then reports completion.

---
 rtl/clk_sw_pkg.sv | 22 ++
 rtl/clk_switch_ctrl_if.sv | 31 +++
 rtl/clk_sw_sync.sv | 26 ++
 rtl/clk_switch_ctrl.sv | 171 +++++++++++++++++
 tb/tb_clk_switch_ctrl.sv | 380 ++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/clk_sw_pkg.sv
// Shared types and helpers for the clock-switch sequencer: FSM state encoding,
// source-index width helper and the fallback source used after an error.
package clk_sw_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ARB,
        GATE_OFF,
        WAIT_OFF,
        GATE_ON,
        WAIT_ON,
        DONE,
        ERR
    } state_e;

    localparam int FALLBACK_SRC = 0;

    function automatic int sw_width(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/clk_switch_ctrl_if.sv
// Requester handshake plus mux enable/acknowledge bundle for clk_switch_ctrl.
// The slave modport is the controller side; master is the requester/mux side.
interface clk_switch_ctrl_if #(
    parameter int NUM_SRC = 4,
    parameter int NUM_REQ = 2
);
    import clk_sw_pkg::*;

    localparam int SW = sw_width(NUM_SRC);

    logic [NUM_REQ-1:0]    req;
    logic [NUM_REQ*SW-1:0] req_src;
    logic [NUM_REQ-1:0]    gnt;
    logic                  done;
    logic                  err;
    logic                  busy;
    logic [SW-1:0]         cur_src;
    logic [NUM_SRC-1:0]    mux_en;
    logic [NUM_SRC-1:0]    mux_ack;

    modport slave (
        input  req, req_src, mux_ack,
        output gnt, done, err, busy, cur_src, mux_en
    );

    modport master (
        output req, req_src, mux_ack,
        input  gnt, done, err, busy, cur_src, mux_en
    );

endinterface

// File: rtl/clk_sw_sync.sv
// Multi-stage flop synchronizer for a vector of asynchronous level signals.
// Each bit is synchronized independently; STAGES must be at least 2.
module clk_sw_sync #(
    parameter int WIDTH  = 1,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_sync [STAGES];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s < STAGES; s++) r_sync[s] <= '0;
        end else begin
            r_sync[0] <= i_d;
            for (int s = 1; s < STAGES; s++) r_sync[s] <= r_sync[s-1];
        end
    end

    assign o_q = r_sync[STAGES-1];

endmodule

// File: rtl/clk_switch_ctrl.sv
// Round-robin arbitrated sequencer for a glitch-free clock mux bank.
// Define CLK_SW_TIMEOUT_EN to bound the off/on acknowledge waits by TIMEOUT cycles.
module clk_switch_ctrl
    import clk_sw_pkg::*;
#(
    parameter int NUM_SRC     = 4,
    parameter int NUM_REQ     = 2,
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT     = 255
) (
    input logic              clk,
    input logic              rst,
    clk_switch_ctrl_if.slave bus
);

    localparam int SW       = sw_width(NUM_SRC);
    localparam int IW       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int TGT_SPAN = 1 << SW;
    localparam logic [NUM_SRC-1:0] SRC_ONE = NUM_SRC'(1);
    localparam logic [NUM_REQ-1:0] REQ_ONE = NUM_REQ'(1);

    if (NUM_SRC < 2 || NUM_SRC > 8 || NUM_REQ < 1 || NUM_REQ > 4 ||
        SYNC_STAGES < 2 || TIMEOUT < 1) begin : g_param_check
        $error("clk_switch_ctrl: parameter out of range");
    end

    state_e               r_state;
    state_e               w_next;
    logic [IW-1:0]        r_rr_ptr;
    logic [IW-1:0]        r_idx;
    logic [SW-1:0]        r_tgt;
    logic [SW-1:0]        r_cur;
    logic [NUM_SRC-1:0]   r_mux_en;
    logic [NUM_SRC-1:0]   w_ack_s;
    logic [TGT_SPAN-1:0]  w_ack_ext;
    logic [TGT_SPAN-1:0]  w_tgt_legal;
    logic                 w_tgt_ok;
    logic                 w_any_req;
    logic [IW-1:0]        w_win_idx;
    logic [SW-1:0]        w_win_src;
    logic                 w_tmo;
    logic [NUM_REQ-1:0]   w_gnt;
    logic                 w_done;
    logic                 w_err;
    logic                 w_busy;

    clk_sw_sync #(
        .WIDTH  (NUM_SRC),
        .STAGES (SYNC_STAGES)
    ) u_ack_sync (
        .clk (clk),
        .rst (rst),
        .i_d (bus.mux_ack),
        .o_q (w_ack_s)
    );

    // Index space of req_src can exceed NUM_SRC; widen ack and mark legal codes.
    assign w_ack_ext = TGT_SPAN'(w_ack_s);
    for (genvar g = 0; g < TGT_SPAN; g++) begin : g_legal
        assign w_tgt_legal[g] = (g < NUM_SRC);
    end
    assign w_tgt_ok = w_tgt_legal[r_tgt];

    // Round-robin scan from r_rr_ptr; descending loop leaves the first hit.
    always_comb begin
        w_any_req = 1'b0;
        w_win_idx = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (bus.req[(int'(r_rr_ptr) + k) % NUM_REQ]) begin
                w_any_req = 1'b1;
                w_win_idx = IW'((int'(r_rr_ptr) + k) % NUM_REQ);
            end
        end
    end
    assign w_win_src = bus.req_src[int'(w_win_idx)*SW +: SW];

`ifdef CLK_SW_TIMEOUT_EN
    localparam int TMO_W = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
    logic [TMO_W-1:0] r_tmo_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_tmo_cnt <= '0;
        end else if (r_state == GATE_OFF || r_state == GATE_ON) begin
            r_tmo_cnt <= '0;
        end else if ((r_state == WAIT_OFF || r_state == WAIT_ON) && !w_tmo) begin
            r_tmo_cnt <= r_tmo_cnt + 1'b1;
        end
    end
    assign w_tmo = (r_tmo_cnt == TMO_W'(TIMEOUT));
`else
    assign w_tmo = 1'b0;
`endif

    always_comb begin
        w_next = r_state;
        w_gnt  = REQ_ONE << r_idx;
        w_done = 1'b0;
        w_err  = 1'b0;
        w_busy = 1'b1;
        case (r_state)
            IDLE: begin
                w_gnt  = '0;
                w_busy = 1'b0;
                if (w_any_req) w_next = ARB;
            end
            ARB: begin
                if (!w_tgt_ok)           w_next = ERR;
                else if (r_tgt == r_cur) w_next = DONE;
                else                     w_next = GATE_OFF;
            end
            GATE_OFF: w_next = WAIT_OFF;
            WAIT_OFF: begin
                if (!w_ack_ext[r_cur]) w_next = GATE_ON;
                else if (w_tmo)        w_next = ERR;
            end
            GATE_ON: w_next = WAIT_ON;
            WAIT_ON: begin
                if (w_ack_ext[r_tgt]) w_next = DONE;
                else if (w_tmo)       w_next = ERR;
            end
            DONE: begin
                w_done = 1'b1;
                w_next = IDLE;
            end
            ERR: begin
                w_err  = 1'b1;
                w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_rr_ptr <= '0;
            r_cur    <= SW'(FALLBACK_SRC);
            r_mux_en <= SRC_ONE << FALLBACK_SRC;
        end else begin
            r_state <= w_next;
            case (r_state)
                IDLE:     if (w_any_req) r_rr_ptr <= IW'((int'(w_win_idx) + 1) % NUM_REQ);
                GATE_OFF: r_mux_en <= '0;
                GATE_ON:  r_mux_en <= SRC_ONE << r_tgt;
                WAIT_ON:  if (w_ack_ext[r_tgt]) r_cur <= r_tgt;
                ERR: begin
                    r_mux_en <= SRC_ONE << FALLBACK_SRC;
                    r_cur    <= SW'(FALLBACK_SRC);
                end
                default: ;
            endcase
        end
    end

    // Winner and its target are captured once, at acceptance.
    always_ff @(posedge clk) begin
        if (r_state == IDLE && w_any_req) begin
            r_idx <= w_win_idx;
            r_tgt <= w_win_src;
        end
    end

    assign bus.gnt     = w_gnt;
    assign bus.done    = w_done;
    assign bus.err     = w_err;
    assign bus.busy    = w_busy;
    assign bus.cur_src = r_cur;
    assign bus.mux_en  = r_mux_en;

endmodule

// File: tb/tb_clk_switch_ctrl.sv
// Scoreboarded random and directed bench for clk_switch_ctrl (4-source/2-requester
// instance plus a 3-source instance for the invalid-target path).
module tb_clk_switch_ctrl;
    import clk_sw_pkg::*;

    localparam int NS  = 4;
    localparam int NR  = 2;
    localparam int SW  = sw_width(NS);
    localparam int TMO = 16;
    localparam int NSB = 3;
    localparam int SWB = sw_width(NSB);

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    clk_switch_ctrl_if #(.NUM_SRC(NS),  .NUM_REQ(NR)) busA ();
    clk_switch_ctrl_if #(.NUM_SRC(NSB), .NUM_REQ(1))  busB ();

    clk_switch_ctrl #(.NUM_SRC(NS), .NUM_REQ(NR), .SYNC_STAGES(2), .TIMEOUT(TMO)) dutA (
        .clk (clk), .rst (rst), .bus (busA));
    clk_switch_ctrl #(.NUM_SRC(NSB), .NUM_REQ(1), .SYNC_STAGES(2), .TIMEOUT(TMO)) dutB (
        .clk (clk), .rst (rst), .bus (busB));

    // Mux models: each ack follows its enable after a programmable delay.
    int             mux_dly = 3;
    logic [NS-1:0]  stuck   = '0;
    logic [NS-1:0]  histA [8];
    logic [NSB-1:0] histB [8];

    always @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < 8; k++) begin
                histA[k] <= '0;
                histB[k] <= '0;
            end
        end else begin
            histA[0] <= busA.mux_en;
            histB[0] <= busB.mux_en;
            for (int k = 1; k < 8; k++) begin
                histA[k] <= histA[k-1];
                histB[k] <= histB[k-1];
            end
        end
    end
    assign busA.mux_ack = histA[mux_dly-1] & ~stuck;
    assign busB.mux_ack = histB[1];

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    // kind: 0 no-op done, 1 real switch, 2 invalid target, 3 timeout
    typedef struct {
        int idx;
        bit is_err;
        int src;
        int kind;
    } exp_t;

    exp_t sb_q[$];
    int   m_cur = 0;
    int   m_ptr = 0;

    // Reference: serve the asserted requesters in round-robin order from m_ptr.
    function automatic void predict(input logic [NR-1:0] mask, input int t0, input int t1);
        int tg [NR];
        logic [NR-1:0] rem;
        int win;
        exp_t e;
        tg[0] = t0;
        tg[1] = t1;
        rem = mask;
        for (int n = 0; n < NR; n++) begin
            win = -1;
            for (int k = 0; k < NR; k++)
                if (win < 0 && rem[(m_ptr + k) % NR]) win = (m_ptr + k) % NR;
            if (win >= 0) begin
                rem[win] = 1'b0;
                m_ptr = (win + 1) % NR;
                e.idx = win;
                if (tg[win] >= NS) begin
                    e.is_err = 1'b1;
                    e.kind = 2;
                    m_cur = 0;
                end else begin
                    e.is_err = 1'b0;
                    e.kind = (tg[win] == m_cur) ? 0 : 1;
                    m_cur = tg[win];
                end
                e.src = m_cur;
                sb_q.push_back(e);
            end
        end
    endfunction

    // Monitor: pops one expectation per done/err pulse, checks state the cycle after.
    logic [NS-1:0] en_log [$];
    logic [NS-1:0] en_prev = '0;
    int   cyc = 0;
    int   t_start = 0;
    bit   prev_busy = 1'b0;
    bit   pend = 1'b0;
    exp_t pend_e;
    exp_t mon_e;

    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (rst) begin
                pend = 1'b0;
                prev_busy = 1'b0;
            end else begin
                chk("mux_en_onehot0", 32'($onehot0(busA.mux_en)), 1);
                chk("gnt_vs_busy", busA.busy ? 32'($onehot(busA.gnt)) : 32'(busA.gnt == '0), 1);
                if (busA.mux_en != en_prev) en_log.push_back(busA.mux_en);
                en_prev = busA.mux_en;
                if (pend) begin
                    chk("cur_src_after", 32'(busA.cur_src), pend_e.src);
                    chk("mux_en_after", 32'(busA.mux_en), 32'(1) << pend_e.src);
                    pend = 1'b0;
                end
                if (busA.busy && !prev_busy) t_start = cyc;
                if (busA.done || busA.err) begin
                    if (sb_q.size() == 0) begin
                        n_cmp++;
                        n_bad++;
                        $display("FAIL unexpected_completion: actual done=%0b err=%0b required none",
                                 busA.done, busA.err);
                    end else begin
                        mon_e = sb_q.pop_front();
                        chk("gnt_owner", 32'(busA.gnt), 32'(1) << mon_e.idx);
                        chk("err_flag", 32'(busA.err), 32'(mon_e.is_err));
                        chk("done_flag", 32'(busA.done), 32'(!mon_e.is_err));
                        if (mon_e.kind == 0 || mon_e.kind == 2)
                            chk("short_latency", cyc - t_start, 1);
                        else if (mon_e.kind == 1)
                            chk("switch_latency_min", 32'((cyc - t_start) >= 5), 1);
                        pend = 1'b1;
                        pend_e = mon_e;
                    end
                end
                prev_busy = busA.busy;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_all();
        rst = 1'b1;
        busA.req = '0;
        busB.req = '0;
        tick();
        tick();
        rst = 1'b0;
        m_cur = 0;
        m_ptr = 0;
        sb_q.delete();
        repeat (10) tick();
    endtask

    // Requesters hold req until their own done/err, then release.
    task automatic run_round(input logic [NR-1:0] mask, input int t0, input int t1, input int budget);
        int n;
        n = 0;
        predict(mask, t0, t1);
        busA.req_src = {SW'(t1), SW'(t0)};
        busA.req = mask;
        while (busA.req != '0 && n < budget) begin
            tick();
            n++;
            if (busA.done || busA.err) busA.req = busA.req & ~busA.gnt;
        end
        if (busA.req != '0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL round_timeout: actual req=%0b still pending required all served", busA.req);
            reset_all();
        end
        repeat (3) tick();
    endtask

    task automatic timeout_test();
        int tgt;
        int t_on;
        int t_err;
        logic [NS-1:0] tgt_oh;
        repeat (9) tick();
        tgt = (m_cur + 1) % NS;
        tgt_oh = NS'(1) << tgt;
        stuck = tgt_oh;
        t_on = -1;
        t_err = -1;
`ifdef CLK_SW_TIMEOUT_EN
        sb_q.push_back('{idx: 0, is_err: 1'b1, src: 0, kind: 3});
        m_cur = 0;
        m_ptr = 1;
`endif
        busA.req_src = {SW'(0), SW'(tgt)};
        busA.req = 2'b01;
        for (int n = 0; n < 300; n++) begin
            tick();
            if (t_on < 0 && busA.mux_en == tgt_oh) t_on = n;
            if (busA.err) begin
                t_err = n;
                busA.req = '0;
                break;
            end
        end
`ifdef CLK_SW_TIMEOUT_EN
        chk("timeout_err_latency", t_err - t_on, TMO + 1);
        tick();
        chk("timeout_fallback_en", 32'(busA.mux_en), 1);
        chk("timeout_fallback_cur", 32'(busA.cur_src), 0);
        stuck = '0;
        repeat (10) tick();
`else
        chk("wait_unbounded_busy", 32'(busA.busy), 1);
        chk("wait_unbounded_no_err", t_err, -1);
        stuck = '0;
        reset_all();
`endif
    endtask

    task automatic invalid_target_test();
        int n_gnt;
        int t_err;
        bit en_moved;
        bit done_seen;
        busB.req_src = SWB'(2);
        busB.req = 1'b1;
        t_err = -1;
        for (int n = 0; n < 100; n++) begin
            tick();
            if (busB.done || busB.err) begin
                t_err = n;
                chk("b_switch_done", 32'(busB.done), 1);
                busB.req = 1'b0;
                break;
            end
        end
        chk("b_switch_completed", 32'(t_err >= 0), 1);
        busB.req = 1'b0;
        tick();
        chk("b_cur_src_2", 32'(busB.cur_src), 2);
        chk("b_mux_en_100", 32'(busB.mux_en), 32'h4);
        repeat (6) tick();
        busB.req_src = SWB'(3);
        busB.req = 1'b1;
        n_gnt = -1;
        t_err = -1;
        en_moved = 1'b0;
        done_seen = 1'b0;
        for (int n = 0; n < 50; n++) begin
            tick();
            if (busB.gnt[0] && n_gnt < 0) n_gnt = n;
            if (busB.mux_en != 3'b100) en_moved = 1'b1;
            if (busB.done) done_seen = 1'b1;
            if (busB.err) begin
                t_err = n;
                busB.req = 1'b0;
                break;
            end
        end
        busB.req = 1'b0;
        chk("b_invalid_err_latency", t_err - n_gnt, 1);
        chk("b_invalid_no_en_change", 32'(en_moved), 0);
        chk("b_invalid_no_done", 32'(done_seen), 0);
        tick();
        chk("b_fallback_en", 32'(busB.mux_en), 1);
        chk("b_fallback_cur", 32'(busB.cur_src), 0);
        chk("b_gnt_released", 32'(busB.gnt), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: actual=no finish required=finish within cycle budget");
        $fatal(1, "watchdog");
    end

    initial begin
        int tgt;
        int n;
        busA.req = '0;
        busA.req_src = '0;
        busB.req = '0;
        busB.req_src = '0;
        rst = 1'b1;
        repeat (3) tick();
        chk("rst_gnt", 32'(busA.gnt), 0);
        chk("rst_done", 32'(busA.done), 0);
        chk("rst_err", 32'(busA.err), 0);
        chk("rst_busy", 32'(busA.busy), 0);
        chk("rst_cur_src", 32'(busA.cur_src), 0);
        chk("rst_mux_en", 32'(busA.mux_en), 1);
        rst = 1'b0;
        repeat (10) tick();

        // Single switch 0 -> 2: enable path must go 0001 -> 0000 -> 0100.
        en_log.delete();
        run_round(2'b01, 2, 0, 100);
        repeat (5) tick();
        chk("seq_len", en_log.size(), 2);
        if (en_log.size() == 2) begin
            chk("seq_gate_off", 32'(en_log[0]), 0);
            chk("seq_gate_on", 32'(en_log[1]), 32'h4);
        end

        // Same-source request is a no-op.
        en_log.delete();
        run_round(2'b10, 0, 2, 50);
        repeat (4) tick();
        chk("noop_en_unchanged", en_log.size(), 0);
        chk("noop_mux_en", 32'(busA.mux_en), 32'h4);

        // Simultaneous requests, then again to confirm the pointer wrapped to 0.
        run_round(2'b11, 1, 3, 200);
        chk("dual_final_cur", 32'(busA.cur_src), 3);
        repeat (9) tick();
        run_round(2'b11, 2, 0, 200);

        // Reset in WAIT_OFF.
        repeat (9) tick();
        tgt = (m_cur + 1) % NS;
        busA.req_src = {SW'(0), SW'(tgt)};
        busA.req = 2'b01;
        n = 0;
        while (busA.mux_en != '0 && n < 50) begin
            tick();
            n++;
        end
        chk("reached_wait_off", 32'(busA.mux_en), 0);
        rst = 1'b1;
        busA.req = '0;
        tick();
        chk("midrst_mux_en", 32'(busA.mux_en), 1);
        chk("midrst_cur_src", 32'(busA.cur_src), 0);
        chk("midrst_gnt", 32'(busA.gnt), 0);
        chk("midrst_busy", 32'(busA.busy), 0);
        rst = 1'b0;
        m_cur = 0;
        m_ptr = 0;
        sb_q.delete();
        repeat (10) tick();
        run_round(2'b01, 2, 0, 100);

        // Random traffic with random mux acknowledge delays.
        for (int r = 0; r < 25; r++) begin
            repeat (9) tick();
            mux_dly = $urandom_range(1, 4);
            run_round(NR'($urandom_range(1, 3)), $urandom_range(0, NS - 1),
                      $urandom_range(0, NS - 1), 300);
        end
        mux_dly = 3;

        timeout_test();
        repeat (9) tick();
        run_round(2'b01, 3, 0, 100);

        invalid_target_test();

        repeat (5) tick();
        chk("scoreboard_drained", sb_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
